// File: rtl/spimem_pkg.sv
// spimem_pkg: shared definitions for the SPI slave memory.
//   - spimem_state_e : FSM state encoding; these 3-bit codes also appear on leds[2:0]
//   - LED_*          : bit positions inside the debug LED bus
//   - RW_READ        : value of the R/W bit that selects a read
package spimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_GET_ADDR     = 3'd1,
        ST_GET_RW       = 3'd2,
        ST_READ_LOAD    = 3'd3,
        ST_READ_SHIFT   = 3'd4,
        ST_WRITE_SHIFT  = 3'd5,
        ST_WRITE_COMMIT = 3'd6
    } spimem_state_e;

    localparam int unsigned LED_STATE_LSB = 0;
    localparam int unsigned LED_STATE_MSB = 2;
    localparam int unsigned LED_ABORT     = 3;

    localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/spi_memory_ctrl_if.sv
// spi_memory_ctrl_if: SPI pad-side signals of the SPI slave memory.
//   sclk_pin, cs_pin, mosi_pin : driven by the SPI master
//   miso_pin, miso_oe          : driven by the slave (miso_pin valid only while miso_oe=1)
// Modports: master (bus master / bench view), slave (memory controller view).
interface spi_memory_ctrl_if;

    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic miso_pin;
    logic miso_oe;

    modport master (
        output sclk_pin, cs_pin, mosi_pin,
        input  miso_pin, miso_oe
    );

    modport slave (
        input  sclk_pin, cs_pin, mosi_pin,
        output miso_pin, miso_oe
    );

endinterface

// File: rtl/spimem_pin_sync.sv
// spimem_pin_sync: multi-flop synchroniser followed by an edge-detect flop.
//   clk, reset      : system clock, asynchronous active-high reset
//   i_pin           : asynchronous pad input
//   o_conditioned   : synchronised pin level
//   o_rise, o_fall  : 1-clk pulses, asserted SYNC_STAGES clk after the pin edge
//                     and therefore acted on SYNC_STAGES+1 clk after it
// RESET_VAL is the idle level of the pin, so leaving reset does not fake an edge.
module spimem_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_conditioned,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_conditioned = r_sync[SYNC_STAGES-1];
    assign o_rise        =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall        = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_memory_ctrl.sv
// spi_memory_ctrl: SPI slave (CPOL=0, CPHA=0) in front of a 2**ADDR_W x DATA_W RAM.
// Frame: ADDR_W address bits, one R/W bit (1=read), then data word(s), MSB first.
//   clk, reset : system clock, asynchronous active-high reset
//   spi        : SPI pads (sclk_pin, cs_pin, mosi_pin in; miso_pin, miso_oe out)
//   busy       : high while a frame is in progress
//   leds       : [2:0] FSM state code, [3] last frame ended before a full data word
// Optional build macro SPIMEM_BURST_EN: after each data word the address
// auto-increments (wrapping) and the transfer continues until cs rises. Without
// it, one word is transferred per frame and further sclk activity is ignored.
module spi_memory_ctrl
    import spimem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_memory_ctrl_if.slave  spi,
    output logic              busy,
    output logic [3:0]        leds
);

    // One shift register serves both the address and the data phase.
    localparam int unsigned SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);

    logic w_sclk_cond, w_sclk_rise, w_sclk_fall;
    logic w_cs_cond,   w_cs_rise,   w_cs_fall;
    logic w_mosi,      w_mosi_rise, w_mosi_fall;

    spimem_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .i_pin(spi.sclk_pin),
        .o_conditioned(w_sclk_cond), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spimem_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .i_pin(spi.cs_pin),
        .o_conditioned(w_cs_cond), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spimem_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .i_pin(spi.mosi_pin),
        .o_conditioned(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spimem_state_e        r_state;
    logic [SH_W-1:0]      r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_miso;
    logic                 r_oe;
    logic                 r_busy;
    logic                 r_abort;
    logic                 r_done;   // at least one full data word finished this frame
    logic                 r_park;   // single-word frame finished: ignore sclk until cs rises
    logic [DATA_W-1:0]    r_mem [2**ADDR_W];

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_last_addr;
    logic                 w_last_data;
    logic [SH_W-1:0]      w_shift_in;
    logic                 w_unused_pins;

    // sclk activity only counts inside an active, non-parked frame.
    assign w_rise      = w_sclk_rise & ~w_cs_cond & ~r_park;
    assign w_fall      = w_sclk_fall & ~w_cs_cond & ~r_park;
    assign w_last_addr = (r_cnt == CNT_W'(ADDR_W - 1));
    assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_shift_in  = {r_shift[SH_W-2:0], w_mosi};

    assign w_unused_pins = &{1'b0, w_sclk_cond, w_mosi_rise, w_mosi_fall, r_shift[SH_W-1]};

`ifdef SPIMEM_BURST_EN
    logic [ADDR_W-1:0] w_addr_next;
    assign w_addr_next = r_addr + 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_miso  <= 1'b0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_done  <= 1'b0;
            r_park  <= 1'b0;
        end else if (w_cs_rise) begin
            // A commit in this same cycle still lands (RAM port below) and counts as a full word.
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_park  <= 1'b0;
            r_abort <= ~(r_done | (r_state == ST_WRITE_COMMIT));
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= ST_GET_ADDR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_park  <= 1'b0;
                    end
                end
                ST_GET_ADDR: begin
                    if (w_rise) begin
                        r_shift <= w_shift_in;
                        if (w_last_addr) begin
                            r_addr  <= w_shift_in[ADDR_W-1:0];
                            r_cnt   <= '0;
                            r_state <= ST_GET_RW;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_GET_RW: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_state <= (w_mosi == RW_READ) ? ST_READ_LOAD : ST_WRITE_SHIFT;
                    end
                end
                ST_READ_LOAD: begin
                    r_shift <= SH_W'(r_mem[r_addr]);
                    r_oe    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_READ_SHIFT;
                end
                ST_READ_SHIFT: begin
                    if (w_fall) begin
                        r_miso  <= r_shift[DATA_W-1];
                        r_shift <= r_shift << 1;
                    end
                    if (w_rise) begin
                        if (w_last_data) begin
                            r_done <= 1'b1;
`ifdef SPIMEM_BURST_EN
                            r_addr  <= w_addr_next;
                            r_state <= ST_READ_LOAD;
`else
                            r_park  <= 1'b1;
                            r_oe    <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE_SHIFT: begin
                    if (w_rise) begin
                        r_shift <= w_shift_in;
                        if (w_last_data) begin
                            r_cnt   <= '0;
                            r_state <= ST_WRITE_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE_COMMIT: begin
                    r_done  <= 1'b1;
                    r_state <= ST_WRITE_SHIFT;
`ifdef SPIMEM_BURST_EN
                    r_addr  <= w_addr_next;
`else
                    r_park  <= 1'b1;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM write port: not reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE_COMMIT) begin
            r_mem[r_addr] <= r_shift[DATA_W-1:0];
        end
    end

    assign spi.miso_pin                       = r_miso;
    assign spi.miso_oe                        = r_oe;
    assign busy                               = r_busy;
    assign leds[LED_ABORT]                    = r_abort;
    assign leds[LED_STATE_MSB:LED_STATE_LSB]  = r_state;

endmodule

// File: tb/tb_spi_memory_ctrl.sv
// tb_spi_memory_ctrl: directed, table-driven bench for spi_memory_ctrl.
// Instance a: default parameters; instance b: ADDR_W=4, DATA_W=16.
module tb_spi_memory_ctrl;

    localparam int H = 10;   // sclk half period in clk cycles

    logic       clk;
    logic       reset;
    logic       a_busy, b_busy;
    logic [3:0] a_leds, b_leds;

    spi_memory_ctrl_if a_if ();
    spi_memory_ctrl_if b_if ();

    spi_memory_ctrl #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .spi(a_if.slave), .busy(a_busy), .leds(a_leds)
    );

    spi_memory_ctrl #(.ADDR_W(4), .DATA_W(16), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .spi(b_if.slave), .busy(b_busy), .leds(b_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        bit          rd;
        logic [15:0] addr;
        logic [47:0] wdata;
        int          nbits;
        logic [47:0] exp_rd;
        logic        exp_abort;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input bit rd, input logic [15:0] a,
                           input logic [47:0] wd, input int nb,
                           input logic [47:0] er, input logic ea);
        vec_t v;
        v.name = nm; v.rd = rd; v.addr = a; v.wdata = wd;
        v.nbits = nb; v.exp_rd = er; v.exp_abort = ea;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pins(input int sel, input logic s, input logic c, input logic m);
        if (sel == 0) begin
            a_if.sclk_pin = s; a_if.cs_pin = c; a_if.mosi_pin = m;
        end else begin
            b_if.sclk_pin = s; b_if.cs_pin = c; b_if.mosi_pin = m;
        end
    endtask

    function automatic logic get_miso(input int sel);
        return (sel == 0) ? a_if.miso_pin : b_if.miso_pin;
    endfunction

    function automatic logic get_oe(input int sel);
        return (sel == 0) ? a_if.miso_oe : b_if.miso_oe;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic [3:0] get_leds(input int sel);
        return (sel == 0) ? a_leds : b_leds;
    endfunction

    // One complete frame; proto_bad counts samples where busy/miso_oe were wrong.
    task automatic frame(input int sel, input int aw, input logic [15:0] addr, input bit rd,
                         input logic [47:0] wdata, input int nbits,
                         output logic [47:0] rdata, output int proto_bad);
        logic b;
        rdata = '0;
        proto_bad = 0;
        set_pins(sel, 1'b0, 1'b0, 1'b0);
        wait_clk(H);
        for (int i = 0; i <= aw; i++) begin
            b = (i < aw) ? addr[aw-1-i] : rd;
            set_pins(sel, 1'b0, 1'b0, b);
            wait_clk(H);
            if (get_oe(sel) !== 1'b0 || get_busy(sel) !== 1'b1) proto_bad++;
            set_pins(sel, 1'b1, 1'b0, b);
            wait_clk(H);
        end
        for (int i = 0; i < nbits; i++) begin
            b = wdata[nbits-1-i];
            set_pins(sel, 1'b0, 1'b0, b);
            wait_clk(H);
            if (rd) begin
                rdata = {rdata[46:0], get_miso(sel)};
                if (get_oe(sel) !== 1'b1) proto_bad++;
            end else if (get_oe(sel) !== 1'b0) begin
                proto_bad++;
            end
            if (get_busy(sel) !== 1'b1) proto_bad++;
            set_pins(sel, 1'b1, 1'b0, b);
            wait_clk(H);
        end
        set_pins(sel, 1'b0, 1'b0, 1'b0);
        wait_clk(H);
        set_pins(sel, 1'b0, 1'b1, 1'b0);
        wait_clk(2*H);
    endtask

    initial begin
        logic [47:0] rdata;
        int          bad;
        logic [3:0]  lv;
        vec_t        v;

        set_pins(0, 1'b0, 1'b1, 1'b0);
        set_pins(1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);

        // Reset state
        check("rst_busy", 48'(a_busy), 48'h0);
        check("rst_oe",   48'(a_if.miso_oe), 48'h0);
        check("rst_miso", 48'(a_if.miso_pin), 48'h0);
        check("rst_leds", 48'(a_leds), 48'h0);
        check("rst_leds_b", 48'(b_leds), 48'h0);

        // Reset asserted in the middle of the address phase
        set_pins(0, 1'b0, 1'b0, 1'b0);
        wait_clk(H);
        for (int i = 0; i < 3; i++) begin
            set_pins(0, 1'b0, 1'b0, 1'b1);
            wait_clk(H);
            set_pins(0, 1'b1, 1'b0, 1'b1);
            wait_clk(H);
        end
        check("midaddr_leds", 48'(a_leds), 48'h1);
        check("midaddr_busy", 48'(a_busy), 48'h1);
        reset = 1'b1;
        #1;
        check("midrst_busy", 48'(a_busy), 48'h0);
        check("midrst_oe",   48'(a_if.miso_oe), 48'h0);
        check("midrst_leds", 48'(a_leds), 48'h0);
        set_pins(0, 1'b0, 1'b1, 1'b0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(H);

        // sclk activity with cs deasserted must be ignored
        for (int i = 0; i < 3; i++) begin
            set_pins(0, 1'b1, 1'b1, 1'b1);
            wait_clk(H);
            set_pins(0, 1'b0, 1'b1, 1'b0);
            wait_clk(H);
        end
        check("cs_hi_busy", 48'(a_busy), 48'h0);
        check("cs_hi_leds", 48'(a_leds), 48'h0);

        // Directed frame table for instance a
        add_vec("wr12_A5",  1'b0, 16'h12, 48'hA5, 8, 48'h0,  1'b0);
        add_vec("rd12",     1'b1, 16'h12, 48'h0,  8, 48'hA5, 1'b0);
        add_vec("wr05_3C",  1'b0, 16'h05, 48'h3C, 8, 48'h0,  1'b0);
        add_vec("wr05_abt", 1'b0, 16'h05, 48'h9,  4, 48'h0,  1'b1);
        add_vec("rd05",     1'b1, 16'h05, 48'h0,  8, 48'h3C, 1'b0);
        add_vec("wr7F_5A",  1'b0, 16'h7F, 48'h5A, 8, 48'h0,  1'b0);
        add_vec("wr00_C3",  1'b0, 16'h00, 48'hC3, 8, 48'h0,  1'b0);
        add_vec("wr11_77",  1'b0, 16'h11, 48'h77, 8, 48'h0,  1'b0);
        add_vec("wr12_88",  1'b0, 16'h12, 48'h88, 8, 48'h0,  1'b0);
        add_vec("wr10_x3",  1'b0, 16'h10, 48'h112233, 24, 48'h0, 1'b0);
        add_vec("rd10",     1'b1, 16'h10, 48'h0,  8, 48'h11, 1'b0);
`ifdef SPIMEM_BURST_EN
        add_vec("rd11",     1'b1, 16'h11, 48'h0,  8, 48'h22, 1'b0);
        add_vec("rd12b",    1'b1, 16'h12, 48'h0,  8, 48'h33, 1'b0);
`else
        add_vec("rd11",     1'b1, 16'h11, 48'h0,  8, 48'h77, 1'b0);
        add_vec("rd12b",    1'b1, 16'h12, 48'h0,  8, 48'h88, 1'b0);
`endif
        add_vec("wr7E_x3",  1'b0, 16'h7E, 48'h112233, 24, 48'h0, 1'b0);
        add_vec("rd7E",     1'b1, 16'h7E, 48'h0,  8, 48'h11, 1'b0);
`ifdef SPIMEM_BURST_EN
        add_vec("rd7F",     1'b1, 16'h7F, 48'h0,  8, 48'h22, 1'b0);
        add_vec("rd00",     1'b1, 16'h00, 48'h0,  8, 48'h33, 1'b0);
        add_vec("rd7F_x2",  1'b1, 16'h7F, 48'h0, 16, 48'h2233, 1'b0);
`else
        add_vec("rd7F",     1'b1, 16'h7F, 48'h0,  8, 48'h5A, 1'b0);
        add_vec("rd00",     1'b1, 16'h00, 48'h0,  8, 48'hC3, 1'b0);
`endif

        foreach (vecs[k]) begin
            v = vecs[k];
            frame(0, 7, v.addr, v.rd, v.wdata, v.nbits, rdata, bad);
            lv = get_leds(0);
            if (v.rd) check({v.name, "_data"}, rdata, v.exp_rd);
            check({v.name, "_abort"}, 48'(lv[3]), 48'(v.exp_abort));
            check({v.name, "_state"}, 48'(lv[2:0]), 48'h0);
            check({v.name, "_busy"},  48'(a_busy), 48'h0);
            check({v.name, "_oe"},    48'(a_if.miso_oe), 48'h0);
            check({v.name, "_proto"}, 48'(bad), 48'h0);
        end

        // RAM contents survive reset
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(H);
        frame(0, 7, 16'h05, 1'b1, 48'h0, 8, rdata, bad);
        check("retain_rd05", rdata, 48'h3C);
        check("retain_proto", 48'(bad), 48'h0);

        // Wide-data instance: ADDR_W=4, DATA_W=16, top address
        frame(1, 4, 16'hF, 1'b0, 48'hBEEF, 16, rdata, bad);
        check("b_wr_proto", 48'(bad), 48'h0);
        lv = get_leds(1);
        check("b_wr_leds", 48'(lv), 48'h0);
        frame(1, 4, 16'hF, 1'b1, 48'h0, 16, rdata, bad);
        check("b_rd_data", rdata, 48'hBEEF);
        check("b_rd_proto", 48'(bad), 48'h0);
        check("b_rd_busy", 48'(b_busy), 48'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_memory_ctrl.md
Name: spi_memory_ctrl

Overview:
- Parametrised SPI slave memory: the next generation of the lab SPI memory.
- Generalised address/data widths; optional burst auto-increment.
- Pin synchronisation, edge detection, FSM, shift register and RAM array all integrated; no external latches.
- Sits between the FPGA SPI pins and the debug LEDs. The master issues address + R/W, then one or more data words.

Parameters:
- ADDR_W, 7, address bits; RAM depth is 2**ADDR_W words.
- DATA_W, 8, data word width in bits.
- SYNC_STAGES, 2, flip-flops in each pin synchroniser (minimum 2).

Ports:
- clk  input  1  FPGA system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sclk_pin  input  1  SPI clock from master (CPOL=0, CPHA=0).
- cs_pin  input  1  SPI chip select, active low.
- mosi_pin  input  1  master out, slave in.
- miso_pin  output  1  slave data out; valid only while miso_oe=1.
- miso_oe  output  1  tri-state enable for the MISO pad buffer.
- busy  output  1  high while a frame is in progress (cs asserted).
- leds  output  4  debug: leds[2:0] = FSM state code, leds[3] = last-frame-aborted flag.

Behaviour:
- Reset: FSM=IDLE; shift register, bit counter and address register cleared. miso_pin=0, miso_oe=0, busy=0, leds=0. RAM contents are not reset; they are retained across reset and undefined at power-up.
- Pin conditioning: each pin passes through SYNC_STAGES flops, then one edge-detect flop.
  - Rise/fall pulses are 1 clk wide, SYNC_STAGES+1 clk after the pin edge.
  - Requirement: sclk high and low phases are each ≥ 2*(SYNC_STAGES+2) clk.
- Sampling and driving:
  - MOSI is sampled on conditioned sclk rising pulses, MSB first.
  - MISO changes on conditioned sclk falling pulses via an output register, so miso_pin is glitch-free.
- FSM states (3-bit codes 0-6): IDLE, GET_ADDR, GET_RW, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT.
  - IDLE -> GET_ADDR on cs falling pulse; busy=1; bit counter cleared.
  - GET_ADDR: shifts in ADDR_W bits. After the ADDR_W-th rising pulse, addr_reg <= shifted bits; -> GET_RW.
  - GET_RW: the next rising pulse samples R/W (1=read). Read -> READ_LOAD; write -> WRITE_SHIFT.
  - READ_LOAD (1 clk): shift register <= mem[addr_reg]; miso_oe=1; -> READ_SHIFT. The next sclk falling pulse drives the MSB.
  - READ_SHIFT: each falling pulse drives the next bit. After the DATA_W-th rising pulse, the word is complete.
  - WRITE_SHIFT: DATA_W rising pulses shift MOSI into the shift register; -> WRITE_COMMIT.
  - WRITE_COMMIT (1 clk): mem[addr_reg] <= shift register.
  - Word completion with burst disabled: both read and write park in an idle-wait, ignoring sclk until cs rises.
- Address arithmetic: addr_reg is ADDR_W bits, modulo 2**ADDR_W; 2**ADDR_W-1 wraps to 0.
- cs rising pulse in any state: -> IDLE next clk; miso_oe=0; busy=0.
  - If the frame did not complete ≥1 full data word, leds[3]=1; otherwise leds[3]=0.
  - A partial write word is discarded; RAM is unchanged.
- Simultaneous events:
  - cs rising on the same clk as WRITE_COMMIT: the commit completes first, then the FSM returns to IDLE.
  - sclk pulses while cs is deasserted are ignored.
  - cs falling while not in IDLE (glitch) is ignored.
- Reset asserted mid-frame: immediate return to the reset values above; any in-flight write is discarded.

Optional Feature:
- Macro: SPIMEM_BURST_EN.
- Defined:
  - After READ_SHIFT completes: addr_reg+1 (wrapping) -> READ_LOAD. That word's MSB goes out on the next falling pulse.
  - After WRITE_COMMIT: addr_reg+1 -> WRITE_SHIFT.
  - Bursts continue until cs rises.
- Not defined: single word per frame (idle-wait as above); the address incrementer logic is absent.

Decomposition:
- Package spimem_pkg holds:
  - the state enum and its 3-bit codes;
  - the LED bit-index constants;
  - the R/W encoding constant (READ=1).
- Sub-module spimem_pin_sync: synchroniser plus edge detector, parametrised by SYNC_STAGES. Outputs conditioned, rise, fall. Instantiated three times.
- RAM is an inferred array inside the top.

Test Plan:
- Reset state: assert reset mid-GET_ADDR -> miso_oe=0, busy=0, leds=0 at once; the next frame decodes normally.
- Write then read: write 0xA5 to addr 0x12, then read addr 0x12 in a new frame -> MISO shifts 1010_0101 MSB first; miso_oe is high only during the data phase.
- Abort: write to addr 0x05 with cs raised after 4 data bits -> mem[0x05] keeps its old value 0x3C; leds[3]=1. A following complete frame clears leds[3]=0.
- Single-word mode, burst macro undefined: write 3 words from addr 0x10 -> only mem[0x10] is updated; mem[0x11]/[0x12] are unchanged.
- Burst wrap, SPIMEM_BURST_EN defined: write 0x11, 0x22, 0x33 starting at addr 0x7E -> mem[0x7E]=0x11, mem[0x7F]=0x22, mem[0x00]=0x33. A burst read from 0x7F returns 0x22, 0x33.
- Parameter sweep at ADDR_W=4, DATA_W=16: write 0xBEEF to addr 0xF, read back -> 0xBEEF.
